// File: rtl/sisc_ctrl_pkg.sv
// sisc_ctrl_pkg: shared state, opcode, pc_sel and alu_op encodings for the
// SISC multi-cycle controller.
package sisc_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_START0    = 3'd0;
  localparam state_t ST_START1    = 3'd1;
  localparam state_t ST_FETCH     = 3'd2;
  localparam state_t ST_DECODE    = 3'd3;
  localparam state_t ST_EXECUTE   = 3'd4;
  localparam state_t ST_MEM       = 3'd5;
  localparam state_t ST_WRITEBACK = 3'd6;
  localparam state_t ST_HALT      = 3'd7;

  localparam int unsigned OPC_NOOP   = 0;
  localparam int unsigned OPC_LOD    = 1;
  localparam int unsigned OPC_STR    = 2;
  localparam int unsigned OPC_SWP    = 3;
  localparam int unsigned OPC_BRA    = 4;
  localparam int unsigned OPC_BRR    = 5;
  localparam int unsigned OPC_BNE    = 6;
  localparam int unsigned OPC_BNR    = 7;
  localparam int unsigned OPC_ALU_OP = 8;
  localparam int unsigned OPC_HLT    = 15;

  localparam int unsigned PC_SEL_W = 2;
  localparam logic [PC_SEL_W-1:0] PC_SEL_INC = 2'd0;
  localparam logic [PC_SEL_W-1:0] PC_SEL_ABS = 2'd1;
  localparam logic [PC_SEL_W-1:0] PC_SEL_REL = 2'd2;

  localparam int unsigned ALU_OP_W    = 2;
  localparam int unsigned ALU_UPD_BIT = 1;
  localparam int unsigned ALU_IMM_BIT = 0;

endpackage

// File: rtl/sisc_ctrl_mc_wait_timer.sv
// ctrl_wait_timer: clear/enable MEM wait counter with an expired flag.
// Only present when CTRL_MEM_WAIT_EN is defined.
`ifdef CTRL_MEM_WAIT_EN
module ctrl_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_f,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at LIMIT so a long stall can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_W'(LIMIT))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // High during the LIMIT-th cycle spent waiting.
  assign expired = (cnt >= CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/sisc_ctrl_mc.sv
// sisc_ctrl_mc: SISC multi-cycle control FSM with branch evaluation and sticky HALT.
// Define CTRL_MEM_WAIT_EN to enable the MEM ready-wait, timeout and mem_err.
module sisc_ctrl_mc
  import sisc_ctrl_pkg::*;
#(
  parameter int unsigned OP_W        = 4,
  parameter int unsigned MM_W        = 4,
  parameter int unsigned IMM_MM      = 8,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_f,
  input  logic [OP_W-1:0]     opcode,
  input  logic [MM_W-1:0]     mm,
  input  logic [MM_W-1:0]     stat,
  input  logic                mem_rdy,
  output logic                rf_we,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                wb_sel,
  output logic                ir_load,
  output logic                pc_write,
  output logic [PC_SEL_W-1:0] pc_sel,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                halted,
  output logic                mem_err
);

  state_t state;
  state_t state_nxt;

  logic is_lod, is_str, is_bra, is_brr, is_bne, is_bnr, is_alu, is_hlt;
  logic is_mem, mask_hit, br_taken, br_rel;
  logic mem_done, mem_fail;

  assign is_lod = (opcode == OP_W'(OPC_LOD));
  assign is_str = (opcode == OP_W'(OPC_STR));
  assign is_bra = (opcode == OP_W'(OPC_BRA));
  assign is_brr = (opcode == OP_W'(OPC_BRR));
  assign is_bne = (opcode == OP_W'(OPC_BNE));
  assign is_bnr = (opcode == OP_W'(OPC_BNR));
  assign is_alu = (opcode == OP_W'(OPC_ALU_OP));
  assign is_hlt = (opcode == OP_W'(OPC_HLT));
  assign is_mem = is_lod | is_str;

  // Branch condition: BRA/BRR on any masked flag set, BNE/BNR on none set.
  assign mask_hit = |(stat & mm);
  assign br_taken = ((is_bra | is_brr) & mask_hit) | ((is_bne | is_bnr) & ~mask_hit);
  assign br_rel   = is_brr | is_bnr;

`ifdef CTRL_MEM_WAIT_EN
  logic in_mem;
  logic expired;

  assign in_mem = (state == ST_MEM);

  ctrl_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_f   (rst_f),
    .clr     (~in_mem),
    .en      (in_mem),
    .expired (expired)
  );

  // mem_rdy takes priority over a timeout landing in the same cycle.
  assign mem_done = ~is_mem | mem_rdy;
  assign mem_fail = in_mem & is_mem & ~mem_rdy & expired;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      mem_err <= 1'b0;
    end else if (mem_fail) begin
      mem_err <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = mem_rdy ^ (MEM_TIMEOUT == 0);
  assign mem_done   = 1'b1;
  assign mem_fail   = 1'b0;
  assign mem_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= ST_START0;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_START0:    state_nxt = ST_START1;
      ST_START1:    state_nxt = ST_FETCH;
      ST_FETCH:     state_nxt = ST_DECODE;
      ST_DECODE:    state_nxt = is_hlt ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE:   state_nxt = ST_MEM;
      ST_MEM: begin
        if (mem_fail) begin
          state_nxt = ST_HALT;
        end else if (mem_done) begin
          state_nxt = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: state_nxt = ST_FETCH;
      ST_HALT:      state_nxt = ST_HALT;
    endcase
  end

  // Strobe decode from the registered state and the current opcode.
  always_comb begin
    rf_we    = 1'b0;
    alu_op   = '0;
    wb_sel   = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = PC_SEL_INC;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    halted   = 1'b0;

    if (is_alu && ((state == ST_EXECUTE) || (state == ST_MEM) || (state == ST_WRITEBACK))) begin
      alu_op[ALU_UPD_BIT] = 1'b1;
      alu_op[ALU_IMM_BIT] = (mm == MM_W'(IMM_MM));
    end

    case (state)
      ST_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        pc_sel   = PC_SEL_INC;
      end
      ST_EXECUTE: begin
        if (br_taken) begin
          pc_write = 1'b1;
          pc_sel   = br_rel ? PC_SEL_REL : PC_SEL_ABS;
        end
      end
      ST_MEM: begin
        mem_rd = is_lod;
        mem_wr = is_str;
      end
      ST_WRITEBACK: begin
        rf_we  = is_alu | is_lod;
        wb_sel = is_lod;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// tb_sisc_ctrl_mc: table-driven directed checks of the SISC multi-cycle controller,
// plus hand-written MEM wait, timeout, HALT and mid-MEM reset sequences.
module tb_sisc_ctrl_mc;

  localparam int unsigned MEM_TO = 4;

  // Observed vector: {rf_we, alu_op[1:0], wb_sel, ir_load, pc_write, pc_sel[1:0],
  //                   mem_rd, mem_wr, halted, mem_err}
  localparam logic [11:0] O_IDLE  = 12'h000;
  localparam logic [11:0] O_FETCH = 12'h0C0;
  localparam logic [11:0] O_LODM  = 12'h008;
  localparam logic [11:0] O_STRM  = 12'h004;
  localparam logic [11:0] O_LODWB = 12'h900;
  localparam logic [11:0] O_HALT  = 12'h002;
  localparam logic [11:0] O_TOERR = 12'h003;

`ifdef CTRL_MEM_WAIT_EN
  localparam int unsigned LOD_MEM_CYC = 4;
`else
  localparam int unsigned LOD_MEM_CYC = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_f = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [3:0] mm = 4'd0;
  logic [3:0] stat = 4'd0;
  logic       mem_rdy = 1'b0;
  logic       rf_we, wb_sel, ir_load, pc_write, mem_rd, mem_wr, halted, mem_err;
  logic [1:0] alu_op, pc_sel;
  logic [11:0] obs;

  int n_checks = 0;
  int n_fail = 0;

  sisc_ctrl_mc #(
    .OP_W        (4),
    .MM_W        (4),
    .IMM_MM      (8),
    .MEM_TIMEOUT (MEM_TO)
  ) dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .opcode   (opcode),
    .mm       (mm),
    .stat     (stat),
    .mem_rdy  (mem_rdy),
    .rf_we    (rf_we),
    .alu_op   (alu_op),
    .wb_sel   (wb_sel),
    .ir_load  (ir_load),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .halted   (halted),
    .mem_err  (mem_err)
  );

  always #5 clk = ~clk;

  assign obs = {rf_we, alu_op, wb_sel, ir_load, pc_write, pc_sel, mem_rd, mem_wr, halted, mem_err};

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [3:0] mm;
    logic [3:0] stat;
    logic [11:0] ex;
    logic [11:0] me;
    logic [11:0] wb;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  // Pulse reset and bring the FSM back to its first FETCH cycle.
  task automatic do_reset(input string tag);
    rst_f = 1'b0;
    #1;
    check({tag, "_async"}, O_IDLE);
    tick();
    tick();
    check({tag, "_held"}, O_IDLE);
    rst_f = 1'b1;
    check({tag, "_start0"}, O_IDLE);
    tick();
    check({tag, "_start1"}, O_IDLE);
    tick();
    check({tag, "_fetch"}, O_FETCH);
  endtask

  task automatic run_vec(input vec_t v);
    opcode = v.op;
    mm     = v.mm;
    stat   = v.stat;
    check({v.name, "_fetch"}, O_FETCH);
    tick();
    check({v.name, "_decode"}, O_IDLE);
    tick();
    check({v.name, "_exec"}, v.ex);
    tick();
    check({v.name, "_mem"}, v.me);
    tick();
    check({v.name, "_wb"}, v.wb);
    tick();
  endtask

  // LOD whose mem_rdy arrives on the last expected MEM cycle.
  task automatic run_lod_wait(input string tag);
    opcode  = 4'd1;
    mem_rdy = 1'b0;
    check({tag, "_fetch"}, O_FETCH);
    tick();
    check({tag, "_decode"}, O_IDLE);
    tick();
    check({tag, "_exec"}, O_IDLE);
    tick();
    for (int i = 0; i < int'(LOD_MEM_CYC); i++) begin
      if (i == int'(LOD_MEM_CYC) - 1) mem_rdy = 1'b1;
      check($sformatf("%s_mem%0d", tag, i), O_LODM);
      tick();
    end
    mem_rdy = 1'b0;
    check({tag, "_wb"}, O_LODWB);
    tick();
    check({tag, "_next_fetch"}, O_FETCH);
  endtask

  initial begin
    vecs[0]  = '{"noop",      4'd0,  4'h0, 4'h0, 12'h000, 12'h000, 12'h000};
    vecs[1]  = '{"alu_imm",   4'd8,  4'h8, 4'h0, 12'h600, 12'h600, 12'hE00};
    vecs[2]  = '{"alu_reg",   4'd8,  4'h3, 4'h0, 12'h400, 12'h400, 12'hC00};
    vecs[3]  = '{"brr_taken", 4'd5,  4'h2, 4'h2, 12'h060, 12'h000, 12'h000};
    vecs[4]  = '{"brr_not",   4'd5,  4'h2, 4'h1, 12'h000, 12'h000, 12'h000};
    vecs[5]  = '{"bne_not",   4'd6,  4'h2, 4'h2, 12'h000, 12'h000, 12'h000};
    vecs[6]  = '{"bne_taken", 4'd6,  4'h2, 4'h1, 12'h050, 12'h000, 12'h000};
    vecs[7]  = '{"bra_taken", 4'd4,  4'hC, 4'h4, 12'h050, 12'h000, 12'h000};
    vecs[8]  = '{"bnr_taken", 4'd7,  4'hF, 4'h0, 12'h060, 12'h000, 12'h000};
    vecs[9]  = '{"lod_fast",  4'd1,  4'h0, 4'h0, 12'h000, 12'h008, 12'h900};
    vecs[10] = '{"str_fast",  4'd2,  4'h0, 4'h0, 12'h000, 12'h004, 12'h000};
    vecs[11] = '{"swp",       4'd3,  4'hF, 4'hF, 12'h000, 12'h000, 12'h000};
    vecs[12] = '{"undef9",    4'd9,  4'h8, 4'h8, 12'h000, 12'h000, 12'h000};

    tick();
    tick();
    check("por_reset", O_IDLE);
    do_reset("rst0");

    mem_rdy = 1'b1;
    foreach (vecs[i]) run_vec(vecs[i]);

    run_lod_wait("lod_wait");

    // STR with mem_rdy stuck low.
    opcode  = 4'd2;
    mem_rdy = 1'b0;
    check("str_to_fetch", O_FETCH);
    tick();
    check("str_to_decode", O_IDLE);
    tick();
    check("str_to_exec", O_IDLE);
    tick();
`ifdef CTRL_MEM_WAIT_EN
    for (int i = 0; i < int'(MEM_TO); i++) begin
      check($sformatf("str_to_mem%0d", i), O_STRM);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("str_to_err%0d", i), O_TOERR);
      tick();
    end
    do_reset("rst_err");
`else
    check("str_nowait_mem", O_STRM);
    tick();
    check("str_nowait_wb", O_IDLE);
    tick();
    check("str_nowait_fetch", O_FETCH);
`endif

    // HLT: sticky halt regardless of later inputs.
    opcode = 4'd15;
    check("hlt_fetch", O_FETCH);
    tick();
    check("hlt_decode", O_IDLE);
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        opcode  = 4'd1;
        mem_rdy = 1'b1;
      end
      check($sformatf("hlt_hold%0d", i), O_HALT);
      tick();
    end
    mem_rdy = 1'b0;
    do_reset("rst_hlt");

    // Reset asserted mid-MEM stall drops mem_rd immediately.
    opcode = 4'd1;
    check("lodrst_fetch", O_FETCH);
    tick();
    check("lodrst_decode", O_IDLE);
    tick();
    check("lodrst_exec", O_IDLE);
    tick();
    check("lodrst_mem0", O_LODM);
`ifdef CTRL_MEM_WAIT_EN
    tick();
    check("lodrst_mem1", O_LODM);
`endif
    #2;
    do_reset("rst_mid_mem");

    run_lod_wait("lod_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sisc_ctrl_mc.md
# sisc_ctrl_mc

Parametrised multi-cycle control FSM for the SISC processor, replacing the first-generation fixed-width controller. Sequences every instruction through fetch/decode/execute/mem/writeback, drives register-file, ALU, PC, and memory strobes, and evaluates conditional branches. Adds three capabilities the first generation lacks:
- a memory-ready wait state with timeout;
- a synthesizable sticky HALT state;
- parametrised field widths.

## Interface
- OP_W, 4, opcode field width
- MM_W, 4, mode/condition-mask field width (must equal status width)
- IMM_MM, 8, mm value that selects the immediate operand for ALU_OP
- MEM_TIMEOUT, 16, maximum MEM wait cycles before error (≥1)
- clk  in  1  single system clock, rising edge
- rst_f  in  1  reset; asynchronous, active-low
- opcode  in  OP_W  instruction opcode from the IR
- mm  in  MM_W  addressing mode / branch condition mask
- stat  in  MM_W  status flags from the ALU status register
- mem_rdy  in  1  memory access complete
- rf_we  out  1  register-file write enable
- alu_op  out  2  bit1 = ALU result/status update, bit0 = immediate operand
- wb_sel  out  1  writeback source: 0 = ALU, 1 = memory
- ir_load  out  1  load instruction register
- pc_write  out  1  PC update strobe
- pc_sel  out  2  0 = PC+1, 1 = absolute target, 2 = PC-relative target
- mem_rd, mem_wr  out  1 each  memory strobes
- halted  out  1  HALT state reached
- mem_err  out  1  sticky memory timeout flag

## Operation
- States and transitions:
  - START0 → START1 → FETCH.
  - FETCH → DECODE → EXECUTE → MEM → WRITEBACK → FETCH.
  - HALT is terminal.
- Opcodes:
  - NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15.
  - SWP and all undefined opcodes execute as NOOP.
- DECODE with opcode HLT → HALT. halted=1 from the next cycle; all strobes are 0; the state is left only by reset.
- Outputs are a function of the registered state and the opcode. Every strobe is 0 outside the states listed below.
  - FETCH: ir_load=1, pc_write=1, pc_sel=0.
  - EXECUTE, branch: taken when (stat & mm)≠0 for BRA/BRR, and when (stat & mm)==0 for BNE/BNR.
    - Taken: pc_write=1; pc_sel=1 for BRA/BNE, pc_sel=2 for BRR/BNR.
    - Not taken: no strobe.
  - EXECUTE, MEM, WRITEBACK with ALU_OP: alu_op = {1, mm==IMM_MM}. It is held steady across these three states.
  - MEM: mem_rd=1 for LOD, mem_wr=1 for STR. The strobe is held until the state exits.
  - WRITEBACK: rf_we=1, wb_sel=0 for ALU_OP; rf_we=1, wb_sel=1 for LOD.
- MEM wait (LOD/STR only):
  - Stays in MEM while mem_rdy=0.
  - Exits to WRITEBACK on the first cycle mem_rdy=1.
  - A wait counter resets on MEM entry. If mem_rdy is still low after MEM_TIMEOUT cycles in MEM: mem_err=1 (sticky), strobes drop, next state is HALT.
- Non-memory opcodes spend exactly one cycle in MEM and ignore mem_rdy.

## Timing
- Reset asserted (any cycle, including mid-MEM stall):
  - state=START0 immediately (asynchronous);
  - all outputs 0, including halted, mem_err, and the wait counter.
- First FETCH occurs on the 3rd rising edge after rst_f rises.
- Instruction latency:
  - 5 cycles, FETCH through WRITEBACK;
  - plus N wait cycles for a memory instruction whose mem_rdy arrives N cycles late;
  - HLT reaches HALT 2 cycles after FETCH.
- mem_rdy high on the first MEM cycle → zero wait.
- mem_rdy and timeout in the same cycle → mem_rdy wins.
- opcode, mm and stat are sampled combinationally and must be stable from DECODE through WRITEBACK.
- pc_write is single-cycle in FETCH and in EXECUTE. No two consecutive cycles carry pc_write.

## Configuration
- CTRL_MEM_WAIT_EN:
  - Defined: MEM wait, wait counter, timeout and mem_err as described above.
  - Undefined: MEM is always one cycle, mem_rdy is ignored, mem_err is tied 0, and no counter is instantiated.

## Structure
- Shared package sisc_ctrl_pkg holds:
  - state encoding (3-bit localparams START0..HALT);
  - opcode constants;
  - pc_sel encodings;
  - alu_op bit positions.
- One sub-module: ctrl_wait_timer.
  - Clear/enable counter of width $clog2(MEM_TIMEOUT+1) with an expired output.
  - Same async reset.
  - Instantiated only under CTRL_MEM_WAIT_EN.

## Test plan
- Reset release, opcode=NOOP → START0, START1, then FETCH on edge 3. ir_load=1 and pc_write=1 in FETCH; no other strobes for 5 cycles.
- ALU_OP, mm=8 → alu_op=2'b11 across EXECUTE..WRITEBACK. Then rf_we=1, wb_sel=0 in WRITEBACK. With mm=3, alu_op=2'b10.
- BRR, mm=4'b0010:
  - stat=4'b0010 → EXECUTE pc_write=1, pc_sel=2.
  - stat=4'b0001 → no pc_write.
  - BNE with the same masks gives the inverse result, with pc_sel=1.
- LOD with mem_rdy high after 3 cycles → mem_rd=1 for 4 MEM cycles. Then WRITEBACK with rf_we=1, wb_sel=1. Total 8 cycles.
- STR with mem_rdy stuck 0, MEM_TIMEOUT=4 → mem_wr for 4 cycles, then mem_err=1 and halted=1. Reset clears both.
- HLT → halted=1 two cycles after FETCH and held 20 cycles. rst_f pulsed low mid-MEM on a separate LOD → mem_rd drops the same cycle.
